// File: rtl/sram_like_arbiter_pkg.sv
// Shared bus definitions for the MIPS core sram-like interconnect:
// owner encoding, arbiter FSM states and transfer-size codes.
package mips_bus_defs;

    typedef enum logic {
        OWN_INST = 1'b0,
        OWN_DATA = 1'b1
    } owner_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_WAIT = 2'd2
    } arb_state_t;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

endpackage

// File: rtl/sram_like_arbiter_arb_pick.sv
// Combinational tie-break between the instruction and data requesters.
// Fixed data priority, or round-robin against the last completed grant.
module arb_pick
    import mips_bus_defs::*;
#(
    parameter int DATA_PRIORITY = 1
) (
    input  logic   i_req,
    input  logic   d_req,
    input  owner_t last_grant,
    output logic   grant_valid,
    output owner_t grant_owner
);

    always_comb begin
        grant_valid = i_req | d_req;
        grant_owner = OWN_INST;
        if (i_req && d_req) begin
            if (DATA_PRIORITY != 0) begin
                grant_owner = OWN_DATA;
            end else begin
                grant_owner = (last_grant == OWN_INST) ? OWN_DATA : OWN_INST;
            end
        end else if (d_req) begin
            grant_owner = OWN_DATA;
        end
    end

endmodule

// File: rtl/sram_like_arbiter.sv
// Shares one sram-like master port between the instruction-fetch and data ports.
// One transaction outstanding at a time; request fields are registered at grant.
module sram_like_arbiter
    import mips_bus_defs::*;
#(
    parameter int DATA_PRIORITY = 1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_addr_ok,
    output logic        i_data_ok,
    output logic [31:0] i_rdata,
    input  logic        d_req,
    input  logic        d_wr,
    input  logic [1:0]  d_size,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic        d_uncached,
    output logic        d_addr_ok,
    output logic        d_data_ok,
    output logic [31:0] d_rdata,
    output logic        m_req,
    output logic        m_wr,
    output logic [1:0]  m_size,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    output logic        m_uncached,
    input  logic        m_addr_ok,
    input  logic        m_data_ok,
    input  logic [31:0] m_rdata
);

    arb_state_t  r_state, w_state_nxt;
    owner_t      r_owner, r_last_grant, w_grant_owner;
    logic        w_grant_valid, w_load, w_addr_hs, w_data_hs;
    logic        r_wr, r_uncached;
    logic [1:0]  r_size;
    logic [31:0] r_addr, r_wdata;

    arb_pick #(
        .DATA_PRIORITY(DATA_PRIORITY)
    ) u_pick (
        .i_req       (i_req),
        .d_req       (d_req),
        .last_grant  (r_last_grant),
        .grant_valid (w_grant_valid),
        .grant_owner (w_grant_owner)
    );

    // m_data_ok outside a live transaction never reaches this decode.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_addr_hs   = 1'b0;
        w_data_hs   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_grant_valid) begin
                    w_load      = 1'b1;
                    w_state_nxt = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (m_addr_ok) begin
                    w_addr_hs   = 1'b1;
                    w_data_hs   = m_data_ok;
                    w_state_nxt = m_data_ok ? ST_IDLE : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (m_data_ok) begin
                    w_data_hs   = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state      <= ST_IDLE;
            r_last_grant <= OWN_INST;
        end else begin
            r_state <= w_state_nxt;
            if (w_data_hs) begin
                r_last_grant <= r_owner;
            end
        end
    end

    // Instruction fetches are always uncached-clear word reads.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_owner    <= OWN_INST;
            r_wr       <= 1'b0;
            r_size     <= 2'd0;
            r_addr     <= 32'd0;
            r_wdata    <= 32'd0;
            r_uncached <= 1'b0;
        end else if (w_load) begin
            r_owner <= w_grant_owner;
            if (w_grant_owner == OWN_DATA) begin
                r_wr       <= d_wr;
                r_size     <= d_size;
                r_addr     <= d_addr;
                r_wdata    <= d_wdata;
                r_uncached <= d_uncached;
            end else begin
                r_wr       <= 1'b0;
                r_size     <= SIZE_WORD;
                r_addr     <= i_addr;
                r_wdata    <= 32'd0;
                r_uncached <= 1'b0;
            end
        end
    end

    assign m_req      = (r_state == ST_ADDR);
    assign m_wr       = r_wr;
    assign m_size     = r_size;
    assign m_addr     = r_addr;
    assign m_wdata    = r_wdata;
    assign m_uncached = r_uncached;

    assign i_addr_ok = w_addr_hs && (r_owner == OWN_INST);
    assign d_addr_ok = w_addr_hs && (r_owner == OWN_DATA);
    assign i_data_ok = w_data_hs && (r_owner == OWN_INST);
    assign d_data_ok = w_data_hs && (r_owner == OWN_DATA);
    assign i_rdata   = m_rdata;
    assign d_rdata   = m_rdata;

endmodule

// File: doc/sram_like_arbiter.md
Name: sram_like_arbiter

Overview:
- Shares one sram-like master port between the instruction-fetch and data-access sram-like ports of the MIPS core.
- Sits after the address-translation stage (physical addresses in) and before the sram-like-to-AXI bridge.
- Keeps at most one transaction outstanding. Selects a winner, latches its request fields, drives them downstream and routes the handshakes back to the owner.
- Carries the data-side uncached flag with the data request.

Parameters:
- DATA_PRIORITY, 1: 1 = data side always wins a tie; 0 = round-robin on a tie, based on the last grant.

Ports:
- clk  in  1  core clock
- resetn  in  1  asynchronous active-low reset
- i_req  in  1  instruction request
- i_addr  in  32  instruction physical address (read only)
- i_addr_ok  out  1  instruction address accepted (1-cycle pulse)
- i_data_ok  out  1  instruction read data valid (1-cycle pulse)
- i_rdata  out  32  instruction read data
- d_req  in  1  data request
- d_wr  in  1  data write enable
- d_size  in  2  data size (0 byte, 1 half, 2 word)
- d_addr  in  32  data physical address
- d_wdata  in  32  data write data
- d_uncached  in  1  data access bypasses the dcache
- d_addr_ok  out  1  data address accepted (1-cycle pulse)
- d_data_ok  out  1  data response (read data valid or write done)
- d_rdata  out  32  data read data
- m_req  out  1  master request
- m_wr  out  1  master write enable
- m_size  out  2  master size
- m_addr  out  32  master address
- m_wdata  out  32  master write data
- m_uncached  out  1  master uncached flag
- m_addr_ok  in  1  slave accepted address
- m_data_ok  in  1  slave response
- m_rdata  in  32  slave read data

Behaviour:
- FSM states: IDLE, ADDR, WAIT.
- Reset (async, resetn=0):
  - state=IDLE, owner=INST, last_grant=INST.
  - All m_* fields 0; m_req=0.
  - All upstream *_addr_ok and *_data_ok = 0.
  - Any in-flight transaction is abandoned. The slave is reset by the same resetn.
- IDLE:
  - If i_req or d_req is high, grant at the clock edge: latch owner and request fields into registers, go to ADDR.
  - Tie, DATA_PRIORITY=1: data wins.
  - Tie, DATA_PRIORITY=0: winner is the side opposite last_grant.
  - Instruction grant latches m_wr=0, m_size=2, m_uncached=0, m_wdata=0.
  - Latency: a request seen in cycle N gives m_req=1 in cycle N+1. There is no combinational path from i_req/d_req to m_req.
- ADDR:
  - m_req=1; m_* driven from the latched registers and held stable until m_addr_ok.
  - When m_addr_ok=1: pulse owner's *_addr_ok in the same cycle (combinational from m_addr_ok and owner) and drop m_req at the next edge.
  - Next state: WAIT, or IDLE if m_data_ok=1 in the same cycle.
- WAIT:
  - m_req=0. When m_data_ok=1: pulse owner's *_data_ok with *_rdata=m_rdata the same cycle, update last_grant=owner, go to IDLE.
- Non-owner: *_addr_ok and *_data_ok are always 0. *_rdata follows m_rdata for both sides, qualified only by *_data_ok.
- Upstream requests:
  - A requester holds req and fields stable until its addr_ok.
  - A request deasserted before grant is simply not served.
  - The losing side stays pending; it is granted at the earliest in the cycle after the winner's data_ok (IDLE pass).
- m_data_ok in IDLE or ADDR without m_addr_ok: protocol error; it is ignored, with no upstream pulse.
- Throughput: at best 1 transaction per 3 cycles when the slave answers addr_ok and data_ok immediately (IDLE→ADDR→WAIT). It is 2 cycles if both arrive in the same cycle.

Decomposition:
- Shared package mips_bus_defs:
  - owner encoding OWN_INST=1'b0, OWN_DATA=1'b1;
  - FSM state encoding;
  - size constants SIZE_BYTE/HALF/WORD.
- One natural sub-module: arb_pick, the combinational tie-break. It takes i_req, d_req, last_grant and DATA_PRIORITY and outputs grant_valid and grant_owner. It can be reused by a future dcache/icache refill arbiter.

Test Plan:
- Single inst read: i_req=1, i_addr=0x1FC0_0000. Expect m_req=1 in cycle 1 with m_addr=0x1FC0_0000, m_wr=0, m_size=2. Slave addr_ok in cycle 2 → i_addr_ok pulse in cycle 2. data_ok in cycle 4 with rdata=0x2408_0001 → i_data_ok and i_rdata=0x2408_0001 in cycle 4; d_* stays 0 throughout.
- Simultaneous, DATA_PRIORITY=1: i_req=d_req=1, d_wr=1, d_addr=0x0000_0100, d_wdata=0xDEAD_BEEF, d_size=2, d_uncached=1. Expect data served first (m_wr=1, m_uncached=1), then the inst request in the next IDLE pass. i_addr_ok stays 0 until the data transaction completes.
- Round-robin, DATA_PRIORITY=0: both sides request continuously for 4 transactions. Expect grant order D,I,D,I after reset (last_grant=INST).
- Same-cycle addr_ok and data_ok: slave returns both in the ADDR cycle. Expect one *_addr_ok and one *_data_ok pulse in that cycle, state back to IDLE next cycle, and the next pending request issued one cycle later.
- Slave stall: m_addr_ok withheld for 5 cycles. Expect m_req=1 with m_addr/m_wdata/m_size unchanged every cycle, even if the requester's fields change.
- Reset mid-transaction: resetn=0 in WAIT. Expect all outputs 0 immediately (asynchronously). A later m_data_ok=1 in IDLE produces no upstream pulse.
